mem_access_ctrl: RTL

Memory-access stage controller, directly downstream of the decode controller. It consumes the decode flags `is_mem_op`, `is_load_op`, `is_store_op` and `is_byte_op`, together with the effective address and store data. It runs a request/response handshake with data memory, handles byte-lane alignment for LBU and SB, and stalls the core until the access completes. For a load, it returns the formatted load value for register-file writeback.

---
 rtl/mem_access_ctrl_pkg.sv | 28 ++
 rtl/mem_access_ctrl_byte_lane_align.sv | 50 +++++
 rtl/mem_access_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory-access stage controller.
// The FSM encoding, the request bundle and the misalignment test live here.
package definitions;

    localparam int kByteLanes = 4;
    localparam int kAddrW     = 32;
    localparam int kDataW     = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic                  we;
        logic [kAddrW-1:0]     addr;
        logic [kDataW-1:0]     data;
        logic [kByteLanes-1:0] mask;
    } dmem_req_s;

    // Only word accesses need natural alignment; byte accesses may hit any lane.
    function automatic logic is_misaligned(input logic is_byte, input logic [1:0] offset);
        return (!is_byte) && (offset != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_align.sv
// Combinational byte-lane steering: store mask/replication and load lane extraction.
// Lanes are little-endian: lane k holds bits 8k+7:8k.
module byte_lane_align
    import definitions::*;
(
    input  logic                  store_is_store,
    input  logic                  store_is_byte,
    input  logic [1:0]            store_offset,
    input  logic [kDataW-1:0]     store_data,
    output logic [kByteLanes-1:0] store_mask,
    output logic [kDataW-1:0]     store_wdata,
    input  logic                  load_is_byte,
    input  logic [1:0]            load_offset,
    input  logic [kDataW-1:0]     rsp_data,
    output logic [kDataW-1:0]     load_data
);

    logic [7:0] lane_byte;

    // Store side: byte stores enable one lane and replicate the byte across the word.
    always_comb begin
        store_mask  = 4'hF;
        store_wdata = store_data;
        if (store_is_store && store_is_byte) begin
            store_mask  = 4'b0001 << store_offset;
            store_wdata = {kByteLanes{store_data[7:0]}};
        end else begin
            store_mask  = 4'hF;
            store_wdata = store_data;
        end
    end

    // Load side: pick the addressed lane and zero-extend it for LBU.
    always_comb begin
        lane_byte = 8'h00;
        case (load_offset)
            2'd0:    lane_byte = rsp_data[7:0];
            2'd1:    lane_byte = rsp_data[15:8];
            2'd2:    lane_byte = rsp_data[23:16];
            2'd3:    lane_byte = rsp_data[31:24];
            default: lane_byte = 8'h00;
        endcase
        if (load_is_byte) begin
            load_data = {24'h000000, lane_byte};
        end else begin
            load_data = rsp_data;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access stage controller: handshakes with data memory, aligns byte lanes
// and stalls the core until the access has completed.
module mem_access_ctrl
    import definitions::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              is_mem_op_i,
    input  logic              is_load_op_i,
    input  logic              is_store_op_i,
    input  logic              is_byte_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              dmem_req_v_o,
    output logic              dmem_req_we_o,
    output logic [ADDR_W-1:0] dmem_req_addr_o,
    output logic [DATA_W-1:0] dmem_req_data_o,
    output logic [3:0]        dmem_req_mask_o,
    input  logic              dmem_req_yumi_i,
    input  logic              dmem_rsp_v_i,
    input  logic [DATA_W-1:0] dmem_rsp_data_i,
    output logic              stall_o,
    output logic              load_data_v_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              misaligned_o
);

    mem_state_e            state_r, state_s;
    dmem_req_s             req_r;
    logic                  is_load_r;
    logic                  is_byte_r;
    logic [1:0]            offset_r;
    logic [DATA_W-1:0]     load_data_r;

    logic                  mem_req_s;
    logic                  bad_align_s;
    logic                  accept_s;
    logic                  stall_s;
    logic                  misaligned_s;
    logic [kByteLanes-1:0] align_mask_s;
    logic [DATA_W-1:0]     align_wdata_s;
    logic [DATA_W-1:0]     align_load_s;

    assign mem_req_s   = valid_i && is_mem_op_i;
    assign bad_align_s = is_misaligned(is_byte_op_i, addr_i[1:0]);
    assign accept_s    = (state_r == IDLE) && mem_req_s && !bad_align_s;

    byte_lane_align u_align (
        .store_is_store (is_store_op_i),
        .store_is_byte  (is_byte_op_i),
        .store_offset   (addr_i[1:0]),
        .store_data     (store_data_i),
        .store_mask     (align_mask_s),
        .store_wdata    (align_wdata_s),
        .load_is_byte   (is_byte_r),
        .load_offset    (offset_r),
        .rsp_data       (dmem_rsp_data_i),
        .load_data      (align_load_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and stall/misalignment decode.
    always_comb begin
        state_s      = state_r;
        stall_s      = 1'b0;
        misaligned_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = REQ;
                    stall_s = 1'b1;
                end else if (mem_req_s && bad_align_s) begin
                    misaligned_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (dmem_req_yumi_i) begin
                    state_s = req_r.we ? DONE : WAIT_RSP;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT_RSP: begin
                stall_s = 1'b1;
                if (dmem_rsp_v_i) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT_RSP;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request capture at accept, and formatted load data at the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_r       <= '0;
            is_load_r   <= 1'b0;
            is_byte_r   <= 1'b0;
            offset_r    <= 2'b00;
            load_data_r <= '0;
        end else if (accept_s) begin
            req_r.we    <= is_store_op_i;
            req_r.addr  <= {addr_i[ADDR_W-1:2], 2'b00};
            req_r.data  <= align_wdata_s;
            req_r.mask  <= align_mask_s;
            is_load_r   <= !is_store_op_i;
            is_byte_r   <= is_byte_op_i;
            offset_r    <= addr_i[1:0];
        end else if ((state_r == WAIT_RSP) && dmem_rsp_v_i) begin
            load_data_r <= align_load_s;
        end
    end

    assign dmem_req_v_o    = (state_r == REQ);
    assign dmem_req_we_o   = req_r.we;
    assign dmem_req_addr_o = req_r.addr;
    assign dmem_req_data_o = req_r.data;
    assign dmem_req_mask_o = req_r.mask;
    assign load_data_v_o   = (state_r == DONE) && is_load_r;
    assign load_data_o     = load_data_r;
    // The reset gate keeps these quiet while the stage is being cleared.
    assign stall_o         = stall_s && !reset;
    assign misaligned_o    = misaligned_s && !reset;

endmodule
